// File: rtl/point_step_pkg.sv
// Shared types and velocity helpers for the point step engine.
// Optional build macro: POINT_FRICTION_EN (tangential friction on every clamp/push-out).
package point_step_pkg;

    typedef enum logic [1:0] {IDLE, INTEGRATE, COLLIDE, DONE} state_t;
    typedef enum logic [1:0] {SIDE_L, SIDE_R, SIDE_T, SIDE_B} side_t;

    function automatic int sat_vel(input int v, input int vsize);
        int hi;
        int lo;
        hi = (1 <<< (vsize - 1)) - 1;
        lo = -(1 <<< (vsize - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    // Magnitude after a damped bounce; the caller applies the outgoing sign.
    function automatic int abs_damp(input int v, input int dshift, input int vsize);
        int a;
        a = (v < 0) ? -v : v;
        return sat_vel(a >>> dshift, vsize);
    endfunction

    function automatic int tangential(input int v, input int fshift, input int vsize);
`ifdef POINT_FRICTION_EN
        return sat_vel(v - (v >>> fshift), vsize);
`else
        return sat_vel(v, vsize);
`endif
    endfunction

endpackage

// File: rtl/aabb_pushout.sv
// Combinational single-box test: strict inside check, shallowest side select
// (tie order L, R, T, B) and the corrected position/velocity for that side.
module aabb_pushout
    import point_step_pkg::*;
#(
    parameter int POSITION_SIZE  = 11,
    parameter int VELOCITY_SIZE  = 8,
    parameter int DAMP_SHIFT     = 1,
    parameter int FRICTION_SHIFT = 2
) (
    input  logic        [POSITION_SIZE-1:0] pos_x_in,
    input  logic        [POSITION_SIZE-1:0] pos_y_in,
    input  logic signed [VELOCITY_SIZE-1:0] vel_x_in,
    input  logic signed [VELOCITY_SIZE-1:0] vel_y_in,
    input  logic        [POSITION_SIZE-1:0] box_x0_in,
    input  logic        [POSITION_SIZE-1:0] box_x1_in,
    input  logic        [POSITION_SIZE-1:0] box_y0_in,
    input  logic        [POSITION_SIZE-1:0] box_y1_in,
    output logic                            hit_out,
    output logic        [POSITION_SIZE-1:0] pos_x_out,
    output logic        [POSITION_SIZE-1:0] pos_y_out,
    output logic signed [VELOCITY_SIZE-1:0] vel_x_out,
    output logic signed [VELOCITY_SIZE-1:0] vel_y_out
);

    logic [POSITION_SIZE-1:0] pen_l, pen_r, pen_t, pen_b;
    side_t side;

    always_comb begin
        hit_out = (pos_x_in > box_x0_in) && (pos_x_in < box_x1_in) &&
                  (pos_y_in > box_y0_in) && (pos_y_in < box_y1_in);
        pen_l = pos_x_in - box_x0_in;
        pen_r = box_x1_in - pos_x_in;
        pen_t = pos_y_in - box_y0_in;
        pen_b = box_y1_in - pos_y_in;

        if (pen_l <= pen_r && pen_l <= pen_t && pen_l <= pen_b) side = SIDE_L;
        else if (pen_r <= pen_t && pen_r <= pen_b)              side = SIDE_R;
        else if (pen_t <= pen_b)                                side = SIDE_T;
        else                                                    side = SIDE_B;

        pos_x_out = pos_x_in;
        pos_y_out = pos_y_in;
        vel_x_out = vel_x_in;
        vel_y_out = vel_y_in;
        if (hit_out) begin
            case (side)
                SIDE_L: begin
                    pos_x_out = box_x0_in;
                    vel_x_out = VELOCITY_SIZE'(-abs_damp(int'(vel_x_in), DAMP_SHIFT, VELOCITY_SIZE));
                    vel_y_out = VELOCITY_SIZE'(tangential(int'(vel_y_in), FRICTION_SHIFT, VELOCITY_SIZE));
                end
                SIDE_R: begin
                    pos_x_out = box_x1_in;
                    vel_x_out = VELOCITY_SIZE'(abs_damp(int'(vel_x_in), DAMP_SHIFT, VELOCITY_SIZE));
                    vel_y_out = VELOCITY_SIZE'(tangential(int'(vel_y_in), FRICTION_SHIFT, VELOCITY_SIZE));
                end
                SIDE_T: begin
                    pos_y_out = box_y0_in;
                    vel_y_out = VELOCITY_SIZE'(-abs_damp(int'(vel_y_in), DAMP_SHIFT, VELOCITY_SIZE));
                    vel_x_out = VELOCITY_SIZE'(tangential(int'(vel_x_in), FRICTION_SHIFT, VELOCITY_SIZE));
                end
                default: begin
                    pos_y_out = box_y1_in;
                    vel_y_out = VELOCITY_SIZE'(abs_damp(int'(vel_y_in), DAMP_SHIFT, VELOCITY_SIZE));
                    vel_x_out = VELOCITY_SIZE'(tangential(int'(vel_x_in), FRICTION_SHIFT, VELOCITY_SIZE));
                end
            endcase
        end
    end

endmodule

// File: rtl/point_step_engine.sv
// One-point timestep engine: gravity, Euler step, screen clamp, then sequential box push-out.
// Build macro POINT_FRICTION_EN enables tangential friction (see point_step_pkg).
module point_step_engine
    import point_step_pkg::*;
#(
    parameter int POSITION_SIZE  = 11,
    parameter int VELOCITY_SIZE  = 8,
    parameter int DT_SHIFT       = 0,
    parameter int GRAVITY        = 1,
    parameter int DAMP_SHIFT     = 1,
    parameter int FRICTION_SHIFT = 2,
    parameter int BOUND_X_MAX    = 639,
    parameter int BOUND_Y_MAX    = 479,
    parameter int NUM_OBST       = 4
) (
    input  logic                                      clk_in,
    input  logic                                      rst_in,
    input  logic                                      begin_in,
    output logic                                      ready_out,
    input  logic        [POSITION_SIZE-1:0]           pos_x_in,
    input  logic        [POSITION_SIZE-1:0]           pos_y_in,
    input  logic signed [VELOCITY_SIZE-1:0]           vel_x_in,
    input  logic signed [VELOCITY_SIZE-1:0]           vel_y_in,
    input  logic [NUM_OBST-1:0][POSITION_SIZE-1:0]    obst_x0_in,
    input  logic [NUM_OBST-1:0][POSITION_SIZE-1:0]    obst_x1_in,
    input  logic [NUM_OBST-1:0][POSITION_SIZE-1:0]    obst_y0_in,
    input  logic [NUM_OBST-1:0][POSITION_SIZE-1:0]    obst_y1_in,
    input  logic [$clog2(NUM_OBST+1)-1:0]             obst_count_in,
    output logic        [POSITION_SIZE-1:0]           new_pos_x,
    output logic        [POSITION_SIZE-1:0]           new_pos_y,
    output logic signed [VELOCITY_SIZE-1:0]           new_vel_x,
    output logic signed [VELOCITY_SIZE-1:0]           new_vel_y,
    output logic                                      collided_out,
    output logic                                      result_out
);

    localparam int CW = $clog2(NUM_OBST + 1);
    localparam int IW = (NUM_OBST > 1) ? $clog2(NUM_OBST) : 1;
    localparam int PW = POSITION_SIZE + 2;

    state_t state_q, state_d;
    logic        [CW-1:0]            cnt_q, cnt_d, k_q, k_d;
    logic        [POSITION_SIZE-1:0] px_q, px_d, py_q, py_d;
    logic signed [VELOCITY_SIZE-1:0] vx_q, vx_d, vy_q, vy_d;
    logic                            col_q, col_d;
    logic        [POSITION_SIZE-1:0] new_pos_x_q, new_pos_x_d, new_pos_y_q, new_pos_y_d;
    logic signed [VELOCITY_SIZE-1:0] new_vel_x_q, new_vel_x_d, new_vel_y_q, new_vel_y_d;
    logic                            collided_q, collided_d, result_q, result_d;

    logic signed [PW-1:0]            sx, sy;
    int                              ivx, ivy;
    logic        [POSITION_SIZE-1:0] ix, iy;
    logic                            icol;
    logic                            last_box;
    logic        [IW-1:0]            box_idx;
    logic                            po_hit;
    logic        [POSITION_SIZE-1:0] po_x, po_y;
    logic signed [VELOCITY_SIZE-1:0] po_vx, po_vy;

    // State register
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (begin_in) state_d = INTEGRATE;
            INTEGRATE: state_d = (cnt_q == '0) ? DONE : COLLIDE;
            COLLIDE:   if (last_box) state_d = DONE;
            default:   state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        ready_out    = (state_q == IDLE);
        result_out   = result_q;
        new_pos_x    = new_pos_x_q;
        new_pos_y    = new_pos_y_q;
        new_vel_x    = new_vel_x_q;
        new_vel_y    = new_vel_y_q;
        collided_out = collided_q;
    end

    // Gravity, Euler step and screen clamp; x clamp runs first so its friction feeds the y clamp.
    always_comb begin
        ivx  = int'(vx_q);
        ivy  = sat_vel(int'(vy_q) + GRAVITY, VELOCITY_SIZE);
        sx   = PW'(int'(px_q) + (ivx <<< DT_SHIFT));
        sy   = PW'(int'(py_q) + (ivy <<< DT_SHIFT));
        ix   = POSITION_SIZE'(sx);
        iy   = POSITION_SIZE'(sy);
        icol = 1'b0;
        if (sx < 0) begin
            ix   = '0;
            ivx  = abs_damp(ivx, DAMP_SHIFT, VELOCITY_SIZE);
            ivy  = tangential(ivy, FRICTION_SHIFT, VELOCITY_SIZE);
            icol = 1'b1;
        end else if (sx > BOUND_X_MAX) begin
            ix   = POSITION_SIZE'(BOUND_X_MAX);
            ivx  = -abs_damp(ivx, DAMP_SHIFT, VELOCITY_SIZE);
            ivy  = tangential(ivy, FRICTION_SHIFT, VELOCITY_SIZE);
            icol = 1'b1;
        end
        if (sy < 0) begin
            iy   = '0;
            ivy  = abs_damp(ivy, DAMP_SHIFT, VELOCITY_SIZE);
            ivx  = tangential(ivx, FRICTION_SHIFT, VELOCITY_SIZE);
            icol = 1'b1;
        end else if (sy > BOUND_Y_MAX) begin
            iy   = POSITION_SIZE'(BOUND_Y_MAX);
            ivy  = -abs_damp(ivy, DAMP_SHIFT, VELOCITY_SIZE);
            ivx  = tangential(ivx, FRICTION_SHIFT, VELOCITY_SIZE);
            icol = 1'b1;
        end
    end

    assign box_idx  = k_q[IW-1:0];
    assign last_box = ((k_q + CW'(1)) == cnt_q);

    aabb_pushout #(
        .POSITION_SIZE  (POSITION_SIZE),
        .VELOCITY_SIZE  (VELOCITY_SIZE),
        .DAMP_SHIFT     (DAMP_SHIFT),
        .FRICTION_SHIFT (FRICTION_SHIFT)
    ) u_pushout (
        .pos_x_in  (px_q),
        .pos_y_in  (py_q),
        .vel_x_in  (vx_q),
        .vel_y_in  (vy_q),
        .box_x0_in (obst_x0_in[box_idx]),
        .box_x1_in (obst_x1_in[box_idx]),
        .box_y0_in (obst_y0_in[box_idx]),
        .box_y1_in (obst_y1_in[box_idx]),
        .hit_out   (po_hit),
        .pos_x_out (po_x),
        .pos_y_out (po_y),
        .vel_x_out (po_vx),
        .vel_y_out (po_vy)
    );

    always_comb begin
        cnt_d       = cnt_q;
        k_d         = k_q;
        px_d        = px_q;
        py_d        = py_q;
        vx_d        = vx_q;
        vy_d        = vy_q;
        col_d       = col_q;
        new_pos_x_d = new_pos_x_q;
        new_pos_y_d = new_pos_y_q;
        new_vel_x_d = new_vel_x_q;
        new_vel_y_d = new_vel_y_q;
        collided_d  = collided_q;
        result_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (begin_in) begin
                    px_d  = pos_x_in;
                    py_d  = pos_y_in;
                    vx_d  = vel_x_in;
                    vy_d  = vel_y_in;
                    col_d = 1'b0;
                    k_d   = '0;
                    cnt_d = (obst_count_in > CW'(NUM_OBST)) ? CW'(NUM_OBST) : obst_count_in;
                end
            end
            INTEGRATE: begin
                px_d  = ix;
                py_d  = iy;
                vx_d  = VELOCITY_SIZE'(ivx);
                vy_d  = VELOCITY_SIZE'(ivy);
                col_d = icol;
                k_d   = '0;
            end
            COLLIDE: begin
                px_d  = po_x;
                py_d  = po_y;
                vx_d  = po_vx;
                vy_d  = po_vy;
                col_d = col_q | po_hit;
                k_d   = k_q + CW'(1);
            end
            default: begin
                new_pos_x_d = px_q;
                new_pos_y_d = py_q;
                new_vel_x_d = vx_q;
                new_vel_y_d = vy_q;
                collided_d  = col_q;
                result_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            cnt_q       <= '0;
            k_q         <= '0;
            px_q        <= '0;
            py_q        <= '0;
            vx_q        <= '0;
            vy_q        <= '0;
            col_q       <= 1'b0;
            new_pos_x_q <= '0;
            new_pos_y_q <= '0;
            new_vel_x_q <= '0;
            new_vel_y_q <= '0;
            collided_q  <= 1'b0;
            result_q    <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            k_q         <= k_d;
            px_q        <= px_d;
            py_q        <= py_d;
            vx_q        <= vx_d;
            vy_q        <= vy_d;
            col_q       <= col_d;
            new_pos_x_q <= new_pos_x_d;
            new_pos_y_q <= new_pos_y_d;
            new_vel_x_q <= new_vel_x_d;
            new_vel_y_q <= new_vel_y_d;
            collided_q  <= collided_d;
            result_q    <= result_d;
        end
    end

endmodule

// File: tb/tb_point_step_engine.sv
// Scoreboard bench for point_step_engine: directed scenarios plus random steps vs an integer model.
module tb_point_step_engine;

    localparam int P  = 11;
    localparam int V  = 8;
    localparam int NB = 4;
    localparam int CW = 3;
    localparam int DT = 0;
    localparam int G  = 1;
    localparam int D  = 1;
    localparam int F  = 2;
    localparam int XM = 639;
    localparam int YM = 479;

    logic clk_in = 1'b0;
    logic rst_in;
    logic begin_in;
    logic ready_out;
    logic        [P-1:0] pos_x_in, pos_y_in;
    logic signed [V-1:0] vel_x_in, vel_y_in;
    logic [NB-1:0][P-1:0] obst_x0_in, obst_x1_in, obst_y0_in, obst_y1_in;
    logic [CW-1:0] obst_count_in;
    logic        [P-1:0] new_pos_x, new_pos_y;
    logic signed [V-1:0] new_vel_x, new_vel_y;
    logic collided_out;
    logic result_out;

    always #5 clk_in = ~clk_in;

    point_step_engine #(
        .POSITION_SIZE(P), .VELOCITY_SIZE(V), .DT_SHIFT(DT), .GRAVITY(G),
        .DAMP_SHIFT(D), .FRICTION_SHIFT(F), .BOUND_X_MAX(XM), .BOUND_Y_MAX(YM),
        .NUM_OBST(NB)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in), .begin_in(begin_in), .ready_out(ready_out),
        .pos_x_in(pos_x_in), .pos_y_in(pos_y_in), .vel_x_in(vel_x_in), .vel_y_in(vel_y_in),
        .obst_x0_in(obst_x0_in), .obst_x1_in(obst_x1_in),
        .obst_y0_in(obst_y0_in), .obst_y1_in(obst_y1_in),
        .obst_count_in(obst_count_in),
        .new_pos_x(new_pos_x), .new_pos_y(new_pos_y),
        .new_vel_x(new_vel_x), .new_vel_y(new_vel_y),
        .collided_out(collided_out), .result_out(result_out)
    );

    typedef struct {
        int x; int y; int vx; int vy; int col; int lat; int acc;
    } exp_t;

    exp_t q[$];
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int nb_x0[NB], nb_x1[NB], nb_y0[NB], nb_y1[NB];
    int m_x0[NB], m_x1[NB], m_y0[NB], m_y1[NB];

    always @(posedge clk_in) cyc <= cyc + 1;

    function automatic void check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endfunction

    function automatic int sat(input int v);
        if (v > 127) return 127;
        if (v < -128) return -128;
        return v;
    endfunction

    function automatic int damp(input int v);
        int a;
        a = (v < 0) ? -v : v;
        return sat(a / (1 << D));
    endfunction

    function automatic int tang(input int v);
`ifdef POINT_FRICTION_EN
        return sat(v - (v >>> F));
`else
        return v;
`endif
    endfunction

    function automatic exp_t model(input int px, input int py, input int vx_i, input int vy_i, input int cnt);
        exp_t e;
        int x, y, vx, vy, c, n, best;
        int pen[4];
        vx = vx_i;
        vy = sat(vy_i + G);
        x  = px + vx * (1 << DT);
        y  = py + vy * (1 << DT);
        c  = 0;
        if (x < 0)       begin x = 0;  vx = damp(vx);  vy = tang(vy); c = 1; end
        else if (x > XM) begin x = XM; vx = -damp(vx); vy = tang(vy); c = 1; end
        if (y < 0)       begin y = 0;  vy = damp(vy);  vx = tang(vx); c = 1; end
        else if (y > YM) begin y = YM; vy = -damp(vy); vx = tang(vx); c = 1; end
        n = (cnt > NB) ? NB : cnt;
        for (int k = 0; k < n; k++) begin
            if (x > m_x0[k] && x < m_x1[k] && y > m_y0[k] && y < m_y1[k]) begin
                pen[0] = x - m_x0[k];
                pen[1] = m_x1[k] - x;
                pen[2] = y - m_y0[k];
                pen[3] = m_y1[k] - y;
                best = 0;
                for (int s = 1; s < 4; s++) if (pen[s] < pen[best]) best = s;
                case (best)
                    0: begin x = m_x0[k]; vx = -damp(vx); vy = tang(vy); end
                    1: begin x = m_x1[k]; vx = damp(vx);  vy = tang(vy); end
                    2: begin y = m_y0[k]; vy = -damp(vy); vx = tang(vx); end
                    default: begin y = m_y1[k]; vy = damp(vy); vx = tang(vx); end
                endcase
                c = 1;
            end
        end
        e.x = x; e.y = y; e.vx = vx; e.vy = vy; e.col = c; e.lat = 2 + n; e.acc = 0;
        return e;
    endfunction

    // Monitor: pops an expectation on every result pulse.
    initial begin : monitor
        exp_t e;
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge clk_in);
            if (result_out) begin
                check("pulse_width_prev_cycle", int'(prev), 0);
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: result_out=1 with no operation outstanding (t=%0t)", $time);
                end else begin
                    e = q.pop_front();
                    check("new_pos_x", int'(new_pos_x), e.x);
                    check("new_pos_y", int'(new_pos_y), e.y);
                    check("new_vel_x", int'(new_vel_x), e.vx);
                    check("new_vel_y", int'(new_vel_y), e.vy);
                    check("collided", int'(collided_out), e.col);
                    check("latency", cyc - e.acc, e.lat);
                end
            end
            prev = result_out;
        end
    end

    task automatic issue(input int px, input int py, input int vx, input int vy,
                         input int cnt, input bit hold, input bit push);
        exp_t e;
        int t;
        t = 0;
        @(negedge clk_in);
        while (!ready_out && t < 100) begin
            @(negedge clk_in);
            t++;
        end
        if (!ready_out) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: ready_out=0 after %0d cycles, required 1", t);
            begin_in = 1'b0;
            return;
        end
        for (int k = 0; k < NB; k++) begin
            obst_x0_in[k[1:0]] = P'(nb_x0[k]);
            obst_x1_in[k[1:0]] = P'(nb_x1[k]);
            obst_y0_in[k[1:0]] = P'(nb_y0[k]);
            obst_y1_in[k[1:0]] = P'(nb_y1[k]);
            m_x0[k] = nb_x0[k];
            m_x1[k] = nb_x1[k];
            m_y0[k] = nb_y0[k];
            m_y1[k] = nb_y1[k];
        end
        pos_x_in      = P'(px);
        pos_y_in      = P'(py);
        vel_x_in      = V'(vx);
        vel_y_in      = V'(vy);
        obst_count_in = CW'(cnt);
        begin_in      = 1'b1;
        @(posedge clk_in);
        @(negedge clk_in);
        if (push) begin
            e = model(px, py, vx, vy, cnt);
            e.acc = cyc;
            q.push_back(e);
        end
        if (!hold) begin_in = 1'b0;
    endtask

    task automatic set_box(input int k, input int x0, input int y0, input int x1, input int y1);
        nb_x0[k] = x0; nb_y0[k] = y0; nb_x1[k] = x1; nb_y1[k] = y1;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (q.size() != 0 && t < 100) begin
            @(negedge clk_in);
            t++;
        end
        check("drain_outstanding", q.size(), 0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        int px, py, vx, vy, cnt, w, h;
        bit hold;
        rst_in = 1'b0;
        begin_in = 1'b0;
        pos_x_in = '0; pos_y_in = '0; vel_x_in = '0; vel_y_in = '0;
        obst_x0_in = '0; obst_x1_in = '0; obst_y0_in = '0; obst_y1_in = '0;
        obst_count_in = '0;
        for (int k = 0; k < NB; k++) set_box(k, 0, 0, 0, 0);
        repeat (3) @(negedge clk_in);
        check("rst_ready", int'(ready_out), 1);
        check("rst_result", int'(result_out), 0);
        check("rst_pos_x", int'(new_pos_x), 0);
        check("rst_vel_y", int'(new_vel_y), 0);
        check("rst_collided", int'(collided_out), 0);
        rst_in = 1'b1;

        issue(10, 10, 3, 0, 0, 1'b0, 1'b1);       // free flight
        issue(100, 478, 0, 5, 0, 1'b0, 1'b1);     // floor clamp
        issue(100, 478, 8, 5, 0, 1'b0, 1'b1);     // floor clamp with tangential speed
        set_box(0, 50, 50, 100, 100);
        issue(52, 70, 4, 0, 1, 1'b0, 1'b1);       // left-face push-out
        issue(0, 0, 0, 127, 0, 1'b0, 1'b1);       // velocity saturation
        issue(2, 100, -10, 0, 0, 1'b0, 1'b1);     // left screen edge
        issue(630, 5, 100, -128, 0, 1'b0, 1'b1);  // right and top edge together
        set_box(0, 50, 50, 60, 100);
        issue(55, 70, 0, 0, 1, 1'b0, 1'b1);       // L/R tie
        issue(50, 70, 0, -1, 1, 1'b0, 1'b1);      // on the box edge: no hit
        set_box(1, 40, 60, 200, 90);
        issue(57, 70, 2, 0, 7, 1'b0, 1'b1);       // count above slot number, chained boxes
        drain();

        issue(10, 10, 3, 0, 0, 1'b1, 1'b1);       // begin_in held across operations
        issue(20, 30, -3, 2, 2, 1'b1, 1'b1);
        issue(300, 200, 5, 5, 0, 1'b0, 1'b1);
        drain();

        for (int k = 0; k < NB; k++) set_box(k, 100 + 100 * k, 100, 180 + 100 * k, 300);
        issue(150, 150, 1, 1, 4, 1'b0, 1'b0);     // aborted by reset
        @(negedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b0;
        #1;
        check("abort_ready", int'(ready_out), 1);
        check("abort_result", int'(result_out), 0);
        check("abort_pos_x", int'(new_pos_x), 0);
        check("abort_pos_y", int'(new_pos_y), 0);
        check("abort_vel_x", int'(new_vel_x), 0);
        check("abort_collided", int'(collided_out), 0);
        @(negedge clk_in);
        rst_in = 1'b1;
        repeat (8) @(negedge clk_in);
        issue(10, 10, 3, 0, 0, 1'b0, 1'b1);

        for (int i = 0; i < 60; i++) begin
            for (int k = 0; k < NB; k++) begin
                px = $urandom_range(0, 500);
                py = $urandom_range(0, 380);
                w  = $urandom_range(2, 140);
                h  = $urandom_range(2, 100);
                set_box(k, px, py, px + w, py + h);
            end
            cnt = $urandom_range(0, 7);
            if ($urandom_range(0, 1) == 1) begin
                px = nb_x0[0] + $urandom_range(0, nb_x1[0] - nb_x0[0]);
                py = nb_y0[0] + $urandom_range(0, nb_y1[0] - nb_y0[0]);
                vx = int'($urandom_range(0, 20)) - 10;
                vy = int'($urandom_range(0, 20)) - 10;
            end else begin
                px = $urandom_range(0, XM);
                py = $urandom_range(0, YM);
                vx = int'($urandom_range(0, 255)) - 128;
                vy = int'($urandom_range(0, 255)) - 128;
            end
            hold = ($urandom_range(0, 3) == 0) && (i != 59);
            issue(px, py, vx, vy, cnt, hold, 1'b1);
        end
        begin_in = 1'b0;
        drain();
        repeat (5) @(negedge clk_in);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
